encoder_8_3_scan: RTL and testbench
===================================

# encoder_8_3_scan

Sequential 8-to-3 priority encoder, the inverse of the team's `decoder_3_8`. It captures an 8-bit request vector and serialises every set bit as a 3-bit index code, highest index first, over a valid/ready handshake. The decoder maps a code to a one-hot line; this block turns a multi-hot line vector back into a stream of codes. Those codes can drive `decoder_3_8.In` directly in loopback benches alongside `clkgen`.

## Interface
Parameters:
- none; widths are fixed at 8 request lines and a 3-bit code.

Ports:
- `clka`  in  1  clock; single clock domain, rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `E`  in  1  enable; low aborts any operation and blocks new captures.
- `start`  in  1  capture strobe; sampled only in IDLE.
- `In`  in  8  request vector; sampled on the capture edge only.
- `out_ready`  in  1  consumer ready for `Out`.
- `Out`  out  3  index of the highest pending request bit.
- `out_valid`  out  1  `Out` holds a valid code.
- `busy`  out  1  high in EMIT.
- `done`  out  1  one-cycle pulse after the last code transfers.
- `zero`  out  1  one-cycle pulse when the captured `In` was 8'h00.
- `cnt`  out  4  popcount of the captured vector (0..8); held until the next capture.

## Operation
- Internal state: 8-bit pending register `pend`; FSM with states IDLE and EMIT.
- IDLE, when `start && E`:
  - load `pend <= In` and `cnt <= popcount(In)`.
  - If `In != 0`, go to EMIT.
  - If `In == 0`, stay in IDLE, pulse `zero`, and leave `done` low.
- EMIT:
  - `Out` is the index of the highest set bit of `pend`; `out_valid` is 1.
  - Transfer occurs on any edge with `out_valid && out_ready`. On transfer, clear that bit in `pend`.
  - If `pend` is zero after the clear, go to IDLE and pulse `done`.
- Stall: while `out_ready` is 0, `Out`, `out_valid` and `pend` hold unchanged.
- `E` low in EMIT aborts the operation:
  - next edge: `pend` = 0, state IDLE, `out_valid` = 0.
  - no `done` pulse; `cnt` holds.
- `start` in EMIT is ignored. `In` changes after capture have no effect.
- `start` with `E` = 0 is ignored.
- Priority: `rst` > `E` abort > transfer > capture.

## Timing
- Reset values, on the first edge with `rst` = 1: `Out` = 3'd0, `out_valid` = 0, `busy` = 0, `done` = 0, `zero` = 0, `cnt` = 0, `pend` = 0, state IDLE.
- Reset mid-EMIT takes effect on the same edge; no `done` pulse.
- All outputs are registered.
- Capture on edge N gives `out_valid` = 1, `busy` = 1, `Out` = first code, all visible after edge N. Latency is 1 cycle.
- With `out_ready` held high, one code transfers per cycle. A vector with k set bits occupies EMIT for exactly k cycles.
- Last transfer on edge M means that after edge M: `out_valid` = 0, `busy` = 0, `done` = 1. `done` returns to 0 after edge M+1.
- `start` is accepted on edge M+1 at the earliest; there are no back-to-back captures across a completion.
- `zero` is high for the single cycle after the capture edge. `busy` never rises for a zero vector.
- `Out` holds its last code when `out_valid` = 0. Consumers qualify with `out_valid`.

## Test plan
- Reset, then `In` = 8'b1001_0010, `start`, `E` = 1, `out_ready` = 1:
  - `Out` = 7, 4, 1 on three consecutive cycles; `cnt` = 3.
  - `done` pulses one cycle after the last transfer.
- `In` = 8'hFF with `out_ready` toggling 1,0,1,0…:
  - `Out` = 7..0, each code held stable through the stall cycles.
  - exactly 8 transfers; `cnt` = 8; then `done`.
- `In` = 8'h00 with `start`: `zero` = 1 for one cycle; `out_valid`, `busy` and `done` stay 0; `cnt` = 0.
- `In` = 8'b0110_0000, drop `E` after the first transfer (`Out` = 6):
  - `out_valid` and `busy` fall on the next edge; no `done`; code 5 is never emitted.
  - a new `start` with `E` = 1 is accepted afterwards.
- `start` asserted with `In` = 8'h01 while EMIT is emitting 8'b1100_0000: the strobe is ignored; only codes 7 and 6 are emitted.
- Loopback: `Out` drives `decoder_3_8.In` with decoder `E` = `out_valid`. For `In` = 8'b0000_1001, the OR of the decoder outputs over the transfer cycles equals 8'b0000_1001. Then assert `rst` mid-stream: all outputs equal their reset values after that edge.

Source files
------------

// File: rtl/encoder_8_3_scan_if.sv
// Request/code bus for encoder_8_3_scan: capture controls in, serialised index codes out.
// The master drives the request side; the slave is the encoder.
interface encoder_8_3_scan_if;
  logic       E;
  logic       start;
  logic [7:0] In;
  logic       out_ready;
  logic [2:0] Out;
  logic       out_valid;
  logic       busy;
  logic       done;
  logic       zero;
  logic [3:0] cnt;

  modport master (
    output E, start, In, out_ready,
    input  Out, out_valid, busy, done, zero, cnt
  );

  modport slave (
    input  E, start, In, out_ready,
    output Out, out_valid, busy, done, zero, cnt
  );
endinterface

// File: rtl/encoder_8_3_scan.sv
// Sequential 8-to-3 priority encoder: captures a request vector and streams the index of
// every set bit, highest first, over a valid/ready handshake.
module encoder_8_3_scan (
  input  logic                  clka,
  input  logic                  rst,
  encoder_8_3_scan_if.slave     bus
);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e     state_q;
  logic [7:0] pend_q;
  logic [2:0] out_q;
  logic       out_valid_q;
  logic       busy_q;
  logic       done_q;
  logic       zero_q;
  logic [3:0] cnt_q;
  logic [7:0] pend_cleared;

  function automatic logic [2:0] top_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // Pending vector as it will look once the code currently on Out has transferred.
  always_comb begin
    pend_cleared = pend_q & ~(8'd1 << out_q);
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      state_q     <= StIdle;
      pend_q      <= 8'd0;
      out_q       <= 3'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      zero_q      <= 1'b0;
      cnt_q       <= 4'd0;
    end else begin
      done_q <= 1'b0;
      zero_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start && bus.E) begin
            pend_q <= bus.In;
            cnt_q  <= popcount(bus.In);
            if (bus.In != 8'd0) begin
              state_q     <= StEmit;
              out_valid_q <= 1'b1;
              busy_q      <= 1'b1;
              out_q       <= top_index(bus.In);
            end else begin
              zero_q <= 1'b1;
            end
          end
        end
        StEmit: begin
          // Abort wins over a transfer on the same edge; Out keeps its last code.
          if (!bus.E) begin
            state_q     <= StIdle;
            pend_q      <= 8'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end else if (bus.out_ready) begin
            pend_q <= pend_cleared;
            if (pend_cleared == 8'd0) begin
              state_q     <= StIdle;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              out_q <= top_index(pend_cleared);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.Out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.zero      = zero_q;
  assign bus.cnt       = cnt_q;

endmodule

// File: tb/tb_encoder_8_3_scan.sv
// Self-checking bench for encoder_8_3_scan: directed scenarios plus randomized vectors and
// handshake stalls, checked against a bit-scan reference model.
module tb_encoder_8_3_scan;

  logic clka = 1'b0;
  logic rst  = 1'b1;

  encoder_8_3_scan_if bus ();

  encoder_8_3_scan dut (
    .clka (clka),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clka = ~clka;

  int checks   = 0;
  int failures = 0;

  int   got[$];
  int   stall_bad;
  int   cyc_used;
  int   done_early;
  logic timed_out;
  logic done_after;
  logic busy_after;
  logic done_after2;

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic capture(input logic [7:0] v);
    bus.In    = v;
    bus.E     = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Reference: indices of set bits, highest first, packed as {count, 4-bit codes}.
  function automatic logic [35:0] pack_ref(input logic [7:0] v);
    logic [31:0] codes;
    int          n;
    codes = 32'd0;
    n     = 0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        codes[n*4 +: 4] = 4'(i);
        n++;
      end
    end
    return {4'(n), codes};
  endfunction

  function automatic logic [35:0] pack_got();
    logic [31:0] codes;
    codes = 32'd0;
    for (int k = 0; k < got.size() && k < 8; k++) codes[k*4 +: 4] = 4'(got[k]);
    return {4'(got.size()), codes};
  endfunction

  // Drains the current stream under a ready pattern (0: always, 1: 1,0,1,0.., 2: random).
  task automatic collect(input int mode);
    logic       rdy;
    logic [2:0] prev_out;
    got.delete();
    stall_bad  = 0;
    cyc_used   = 0;
    done_early = 0;
    timed_out  = 1'b0;
    while (bus.out_valid === 1'b1 && cyc_used < 100) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc_used % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = rdy;
      prev_out      = bus.Out;
      if (bus.done !== 1'b0) done_early++;
      tick();
      if (rdy) got.push_back(int'(prev_out));
      else if (bus.Out !== prev_out || bus.out_valid !== 1'b1) stall_bad++;
      cyc_used++;
    end
    if (cyc_used >= 100) timed_out = 1'b1;
    done_after    = bus.done;
    busy_after    = bus.busy;
    bus.out_ready = 1'b1;
    tick();
    done_after2 = bus.done;
  endtask

  task automatic test_reset();
    bus.E = 1'b0; bus.start = 1'b0; bus.In = 8'h00; bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.Out, bus.out_valid, bus.busy, bus.done, bus.zero, bus.cnt} !== 11'd0) begin
      failures++;
      $display("FAIL reset_outputs: got Out=%0d v=%b b=%b d=%b z=%b cnt=%0d, want all zero",
               bus.Out, bus.out_valid, bus.busy, bus.done, bus.zero, bus.cnt);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got valid=%b busy=%b, want 0 0", bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_basic();
    logic [7:0] v;
    v = 8'b1001_0010;
    bus.out_ready = 1'b1;
    capture(v);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1 || bus.Out !== 3'd7) begin
      failures++;
      $display("FAIL basic_first: got valid=%b busy=%b Out=%0d, want 1 1 7",
               bus.out_valid, bus.busy, bus.Out);
    end
    checks++;
    if (bus.cnt !== 4'd3) begin
      failures++;
      $display("FAIL basic_cnt: got %0d want 3", bus.cnt);
    end
    collect(0);
    checks++;
    if (pack_got() !== pack_ref(v)) begin
      failures++;
      $display("FAIL basic_codes: got %h want %h", pack_got(), pack_ref(v));
    end
    checks++;
    if (cyc_used != 3) begin
      failures++;
      $display("FAIL basic_emit_cycles: got %0d want 3", cyc_used);
    end
    checks++;
    if (done_after !== 1'b1 || busy_after !== 1'b0 || done_after2 !== 1'b0 || done_early != 0) begin
      failures++;
      $display("FAIL basic_done_pulse: got done=%b busy=%b next_done=%b early=%0d, want 1 0 0 0",
               done_after, busy_after, done_after2, done_early);
    end
  endtask

  task automatic test_stall_toggle();
    capture(8'hFF);
    collect(1);
    checks++;
    if (pack_got() !== pack_ref(8'hFF)) begin
      failures++;
      $display("FAIL toggle_codes: got %h want %h", pack_got(), pack_ref(8'hFF));
    end
    checks++;
    if (stall_bad != 0 || timed_out) begin
      failures++;
      $display("FAIL toggle_stall_hold: got %0d unstable stalls timeout=%b, want 0 0",
               stall_bad, timed_out);
    end
    checks++;
    if (bus.cnt !== 4'd8 || done_after !== 1'b1) begin
      failures++;
      $display("FAIL toggle_cnt_done: got cnt=%0d done=%b, want 8 1", bus.cnt, done_after);
    end
  endtask

  task automatic test_zero();
    capture(8'h00);
    checks++;
    if (bus.zero !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.cnt !== 4'd0) begin
      failures++;
      $display("FAIL zero_capture: got z=%b v=%b b=%b d=%b cnt=%0d, want 1 0 0 0 0",
               bus.zero, bus.out_valid, bus.busy, bus.done, bus.cnt);
    end
    tick();
    checks++;
    if (bus.zero !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL zero_pulse_end: got z=%b b=%b d=%b, want 0 0 0", bus.zero, bus.busy, bus.done);
    end
  endtask

  task automatic test_abort();
    bus.out_ready = 1'b1;
    capture(8'b0110_0000);
    checks++;
    if (bus.Out !== 3'd6 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL abort_first: got Out=%0d v=%b, want 6 1", bus.Out, bus.out_valid);
    end
    tick();
    bus.E = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL abort_stop: got v=%b b=%b d=%b, want 0 0 0",
               bus.out_valid, bus.busy, bus.done);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.out_valid !== 1'b0 || bus.cnt !== 4'd2) begin
      failures++;
      $display("FAIL abort_after: got d=%b v=%b cnt=%0d, want 0 0 2",
               bus.done, bus.out_valid, bus.cnt);
    end
    // start with E low is ignored
    bus.In = 8'h80; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.cnt !== 4'd2) begin
      failures++;
      $display("FAIL start_e_low: got v=%b cnt=%0d, want 0 2", bus.out_valid, bus.cnt);
    end
    capture(8'b0000_0100);
    checks++;
    if (bus.Out !== 3'd2 || bus.out_valid !== 1'b1 || bus.cnt !== 4'd1) begin
      failures++;
      $display("FAIL abort_restart: got Out=%0d v=%b cnt=%0d, want 2 1 1",
               bus.Out, bus.out_valid, bus.cnt);
    end
    collect(0);
  endtask

  task automatic test_start_ignored();
    bus.out_ready = 1'b1;
    capture(8'b1100_0000);
    bus.In = 8'h01; bus.start = 1'b1;
    tick();
    checks++;
    if (bus.Out !== 3'd6 || bus.out_valid !== 1'b1 || bus.cnt !== 4'd2) begin
      failures++;
      $display("FAIL ignore_start_mid: got Out=%0d v=%b cnt=%0d, want 6 1 2",
               bus.Out, bus.out_valid, bus.cnt);
    end
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.done !== 1'b1 || bus.cnt !== 4'd2) begin
      failures++;
      $display("FAIL ignore_start_end: got v=%b d=%b cnt=%0d, want 0 1 2",
               bus.out_valid, bus.done, bus.cnt);
    end
    tick();
  endtask

  task automatic test_loopback_reset();
    logic [7:0] acc;
    bus.out_ready = 1'b1;
    capture(8'b0000_1001);
    collect(0);
    acc = 8'd0;
    for (int k = 0; k < got.size(); k++) acc = acc | (8'd1 << got[k]);
    checks++;
    if (acc !== 8'b0000_1001) begin
      failures++;
      $display("FAIL loopback_or: got %b want 00001001", acc);
    end
    capture(8'hFF);
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.Out, bus.out_valid, bus.busy, bus.done, bus.zero, bus.cnt} !== 11'd0) begin
      failures++;
      $display("FAIL reset_midstream: got Out=%0d v=%b b=%b d=%b z=%b cnt=%0d, want all zero",
               bus.Out, bus.out_valid, bus.busy, bus.done, bus.zero, bus.cnt);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_resume: got v=%b d=%b, want 0 0", bus.out_valid, bus.done);
    end
  endtask

  task automatic test_random();
    logic [7:0] v;
    for (int n = 0; n < 25; n++) begin
      v = 8'($urandom_range(1, 255));
      capture(v);
      checks++;
      if (bus.cnt !== pack_ref(v)[35:32]) begin
        failures++;
        $display("FAIL rand_cnt[%0d]: vec=%h got %0d want %0d", n, v, bus.cnt, pack_ref(v)[35:32]);
      end
      collect(2);
      checks++;
      if (pack_got() !== pack_ref(v) || stall_bad != 0 || timed_out) begin
        failures++;
        $display("FAIL rand_stream[%0d]: vec=%h got %h want %h stalls=%0d timeout=%b",
                 n, v, pack_got(), pack_ref(v), stall_bad, timed_out);
      end
      checks++;
      if (done_after !== 1'b1 || done_after2 !== 1'b0 || done_early != 0) begin
        failures++;
        $display("FAIL rand_done[%0d]: got %b %b early=%0d, want 1 0 0",
                 n, done_after, done_after2, done_early);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall_toggle();
    test_zero();
    test_abort();
    test_start_ignored();
    test_loopback_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
